seqdet_ctrl: RTL and testbench



---
 rtl/seqdet_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seqdet_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_ctrl.sv
// rtl/seqdet_ctrl.sv - byte-fed serial pattern detector with match counting and threshold interrupt
module seqdet_ctrl #(
  parameter int DW = 8,
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pattern,
  input  logic [3:0]    cfg_len,
  input  logic [CW-1:0] cfg_thresh,
  input  logic          start,
  input  logic          stop,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          match,
  output logic [CW-1:0] match_cnt,
  output logic          irq,
  input  logic          irq_clr
);

  localparam int LW = $clog2(PW + 1);
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [4:0] PW5 = 5'(PW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SER, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pattern_q, pattern_d;
  logic [LW-1:0] len_q, len_d;
  logic [CW-1:0] thresh_q, thresh_d;
  logic [PW-1:0] hist_q, hist_d;
  logic [LW-1:0] seen_q, seen_d;
  logic [DW-1:0] byte_q, byte_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          stop_q, stop_d;
  logic          match_q, match_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          irq_q, irq_d;

  logic [PW-1:0] hist_new, mask;
  logic [LW-1:0] seen_new;
  logic [CW-1:0] cnt_inc;
  logic          hit;

  assign in_ready  = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;

  // Compare window is the newest len bits, including the bit being consumed now.
  always_comb begin
    hist_new = {hist_q[PW-2:0], byte_q[idx_q]};
    seen_new = (seen_q == LW'(PW)) ? seen_q : seen_q + 1'b1;
    for (int i = 0; i < PW; i++) begin
      mask[i] = (LW'(i) < len_q);
    end
    hit     = (seen_new >= len_q) && ((hist_new & mask) == (pattern_q & mask));
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    thresh_d  = thresh_q;
    hist_d    = hist_q;
    seen_d    = seen_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;
    irq_d     = irq_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          len_d     = ((cfg_len == 4'd0) || ({1'b0, cfg_len} > PW5)) ? LW'(PW) : LW'(cfg_len);
          thresh_d  = cfg_thresh;
        end
        if (irq_clr) begin
          irq_d = 1'b0;
          cnt_d = '0;
        end
        if (start && !stop) begin
          state_d = S_RUN;
          cnt_d   = '0;
          hist_d  = '0;
          seen_d  = '0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          byte_d  = in_data;
          idx_d   = IW'(DW - 1);
          stop_d  = stop;
          state_d = S_SER;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      S_SER: begin
        hist_d  = hist_new;
        seen_d  = seen_new;
        match_d = hit;
        stop_d  = stop_q | stop;
        if (hit) cnt_d = cnt_inc;
        // Reaching the threshold abandons whatever is left of the byte.
        if (hit && (thresh_q != '0) && (cnt_inc == thresh_q)) begin
          irq_d   = 1'b1;
          state_d = S_HALT;
        end else if (idx_q == '0) begin
          state_d = (stop_q || stop) ? S_IDLE : S_RUN;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_HALT: begin
        if (irq_clr) begin
          irq_d   = 1'b0;
          cnt_d   = '0;
          hist_d  = '0;
          seen_d  = '0;
          state_d = S_RUN;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      len_q     <= LW'(PW);
      thresh_q  <= '0;
      hist_q    <= '0;
      seen_q    <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      thresh_q  <= thresh_d;
      hist_q    <= hist_d;
      seen_q    <= seen_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_seqdet_ctrl.sv
// tb/tb_seqdet_ctrl.sv - seqdet_ctrl bench: queue-based reference model plus directed and random stimulus
module tb_seqdet_ctrl;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [3:0]    cfg_len = '0;
  logic [CW-1:0] cfg_thresh = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, busy, match, irq;
  logic [CW-1:0] match_cnt;
  logic          irq_clr = 1'b0;

  seqdet_ctrl #(.DW(DW), .PW(PW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .match(match), .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [7:0] m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 accepting, 2 shifting bits, 3 halted on irq.
  int        m_mode = 0;
  bit        m_bits[$];
  bit        m_hist[$];
  bit        m_b;
  logic [7:0] m_pat = '0;
  int        m_len = PW;
  logic [7:0] m_thr = '0;
  logic      m_match = 1'b0;
  int        m_cnt = 0;
  logic      m_irq = 1'b0;
  logic      m_stop = 1'b0;

  function automatic bit model_hit();
    if (m_hist.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_bits.delete(); m_hist.delete(); m_pat = '0; m_len = PW;
      m_thr = '0; m_match = 1'b0; m_cnt = 0; m_irq = 1'b0; m_stop = 1'b0;
    end else begin
      m_match = 1'b0;
      case (m_mode)
        0: begin
          if (cfg_we) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0 || cfg_len > PW) ? PW : int'(cfg_len);
            m_thr = cfg_thresh;
          end
          if (irq_clr) begin m_irq = 1'b0; m_cnt = 0; end
          if (start && !stop) begin m_mode = 1; m_cnt = 0; m_hist.delete(); end
        end
        1: begin
          if (in_valid) begin
            m_bits.delete();
            for (int i = DW - 1; i >= 0; i--) m_bits.push_back(in_data[i]);
            m_stop = stop;
            m_mode = 2;
          end else if (stop) m_mode = 0;
        end
        2: begin
          m_b = m_bits.pop_front();
          m_hist.push_back(m_b);
          if (m_hist.size() > PW) m_b = m_hist.pop_front();
          m_stop = m_stop | stop;
          if (model_hit()) begin
            m_match = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
            if (m_thr != 0 && m_cnt == int'(m_thr)) begin
              m_irq = 1'b1; m_mode = 3; m_bits.delete();
            end
          end
          if (m_mode == 2 && m_bits.size() == 0) m_mode = m_stop ? 0 : 1;
        end
        default: begin
          if (irq_clr) begin m_irq = 1'b0; m_cnt = 0; m_hist.delete(); m_mode = 1; end
          else if (stop) m_mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_in_ready", in_ready, m_mode == 1);
      check("cyc_busy", busy, m_mode != 0);
      check("cyc_match", match, m_match);
      check("cyc_match_cnt", match_cnt, m_cnt);
      check("cyc_irq", irq, m_irq);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_at, output logic [7:0] mask);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
    mask = '0;
    for (int k = 1; k <= DW; k++) begin
      stop = (k == stop_at);
      tick();
      if (match) mask[k-1] = 1'b1;
    end
    stop = 1'b0;
  endtask

  initial begin
    // Reset held with live inputs
    in_valid = 1'b1; start = 1'b1;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_irq", irq, 0);
    in_valid = 1'b0; start = 1'b0; rst = 1'b1;
    chk_en = 1'b1;
    do_start();
    send_byte(8'h00, 0, m);
    check("rst_len_mask", m, 8'h80);
    check("rst_len_cnt", match_cnt, 1);
    do_stop();

    // 0x55 full-length, then overlapping
    configure(8'h55, 4'd8, 8'd0); do_start();
    send_byte(8'h55, 0, m);
    check("s2_mask1", m, 8'h80);
    check("s2_cnt1", match_cnt, 1);
    send_byte(8'h55, 0, m);
    check("s2_mask2", m, 8'hAA);
    check("s2_cnt2", match_cnt, 5);
    do_stop();

    // 101 in 0xAD
    configure(8'h05, 4'd3, 8'd0); do_start();
    send_byte(8'hAD, 0, m);
    check("s3_mask", m, 8'h94);
    check("s3_cnt", match_cnt, 3);
    check("s3_ready", in_ready, 1);
    do_stop();

    // Threshold 2 halts mid-byte
    configure(8'h05, 4'd3, 8'd2); do_start();
    send_byte(8'hAD, 0, m);
    check("s4_mask", m, 8'h14);
    check("s4_irq", irq, 1);
    check("s4_ready", in_ready, 0);
    check("s4_busy", busy, 1);
    check("s4_cnt", match_cnt, 2);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check("s4_clr_irq", irq, 0);
    check("s4_clr_cnt", match_cnt, 0);
    check("s4_clr_ready", in_ready, 1);

    // Async reset in the middle of serialisation
    in_valid = 1'b1; in_data = 8'hAD; tick(); in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    check("s5_busy", busy, 0);
    check("s5_match", match, 0);
    check("s5_cnt", match_cnt, 0);
    check("s5_irq", irq, 0);
    check("s5_ready", in_ready, 0);
    tick(); tick(); rst = 1'b1;
    configure(8'h05, 4'd3, 8'd0); do_start();
    send_byte(8'hAD, 0, m);
    check("s5_mask", m, 8'h94);
    check("s5_cnt2", match_cnt, 3);

    // cfg_we ignored outside IDLE; stop during SER finishes the byte
    configure(8'hFF, 4'd8, 8'd1);
    send_byte(8'hAD, 0, m);
    check("s6_mask", m, 8'h94);
    check("s6_cnt", match_cnt, 6);
    send_byte(8'hAD, 3, m);
    check("s6_stop_mask", m, 8'h94);
    check("s6_stop_cnt", match_cnt, 9);
    check("s6_stop_busy", busy, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("s6_startstop", busy, 0);

    // Counter saturation keeps pulsing
    configure(8'h01, 4'd1, 8'd0); do_start();
    repeat (32) send_byte(8'hFF, 0, m);
    check("sat_cnt", match_cnt, CMAX);
    send_byte(8'hFF, 0, m);
    check("sat_mask", m, 8'hFF);
    check("sat_cnt2", match_cnt, CMAX);
    do_stop();

    // Out-of-range lengths mean PW
    configure(8'hA5, 4'd0, 8'd0); do_start();
    send_byte(8'hA5, 0, m);
    check("len0_mask", m, 8'h80);
    do_stop();
    configure(8'hA5, 4'd12, 8'd0); do_start();
    send_byte(8'hA5, 0, m);
    check("len12_mask", m, 8'h80);
    do_stop();

    // Stop from HALT holds irq; irq_clr in IDLE clears it
    configure(8'h05, 4'd3, 8'd1); do_start();
    send_byte(8'hAD, 0, m);
    check("halt_irq", irq, 1);
    do_stop();
    check("halt_stop_busy", busy, 0);
    check("halt_stop_irq", irq, 1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check("idle_clr_irq", irq, 0);
    check("idle_clr_cnt", match_cnt, 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      cfg_we      = ($urandom % 8) == 0;
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom % 16);
      cfg_thresh  = 8'($urandom % 5);
      start       = ($urandom % 4) == 0;
      in_valid    = ($urandom % 2) == 1;
      in_data     = 8'($urandom);
      stop        = !in_valid && (($urandom % 32) == 0);
      irq_clr     = ($urandom % 16) == 0;
      tick();
    end
    cfg_we = 1'b0; start = 1'b0; in_valid = 1'b0; stop = 1'b0; irq_clr = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
